// File: rtl/mem_stage.sv
// mem_stage: memory-access stage behind execute. Captures execute results,
// runs one 64-bit LD/SD on the data-memory port at a time, and emits one
// registered writeback record per accepted instruction.
//
// Handshakes: a channel transfers on a rising clock edge where both valid
// and ready are high. A producer holds valid and its payload stable until
// that edge. ex_ready depends only on FSM state, and the response channel
// has no ready (a response is consumed the cycle it is presented).
module mem_stage #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // execute-stage input channel
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [XLEN-1:0]       ex_alu_result,
    input  logic [XLEN-1:0]       ex_store_data,
    input  logic                  ex_mem_we,
    input  logic                  ex_mem_to_reg,
    input  logic                  ex_rd_we,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    // data-memory request channel
    output logic                  dmem_req_valid,
    input  logic                  dmem_req_ready,
    output logic                  dmem_req_we,
    output logic [XLEN-1:0]       dmem_req_addr,
    output logic [XLEN-1:0]       dmem_req_wdata,
    // data-memory response channel
    input  logic                  dmem_rsp_valid,
    input  logic [XLEN-1:0]       dmem_rsp_rdata,
    // writeback record
    output logic                  wb_valid,
    output logic                  wb_rd_we,
    output logic [REG_ADDR_W-1:0] wb_rd_addr,
    output logic [XLEN-1:0]       wb_data,
    output logic                  misalign_err,
    // debug view of the FSM state (IDLE=0, REQ=1, WAIT_RSP=2)
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } state_t;

    state_t                  state_q;

    // captured memory-op fields, held stable while the request is pending
    logic [XLEN-1:0]         addr_q;
    logic [XLEN-1:0]         wdata_q;
    logic                    store_q;
    logic                    rd_we_q;
    logic [REG_ADDR_W-1:0]   rd_addr_q;

    // registered writeback outputs
    logic                    wb_valid_q;
    logic                    wb_rd_we_q;
    logic [REG_ADDR_W-1:0]   wb_rd_addr_q;
    logic [XLEN-1:0]         wb_data_q;
    logic                    misalign_q;

    logic                    ex_fire;
    logic                    ex_is_mem;
    logic                    ex_misaligned;
    logic                    ex_rd_nz;

    assign ex_fire       = ex_valid && (state_q == IDLE);
    assign ex_is_mem     = ex_mem_we || ex_mem_to_reg;
    assign ex_misaligned = (ex_alu_result[2:0] != 3'b000);
    assign ex_rd_nz      = (ex_rd_addr != '0);

    // FSM plus all captured and writeback registers; a store flag wins over a
    // load flag, so a store never writes the register file.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            store_q      <= 1'b0;
            rd_we_q      <= 1'b0;
            rd_addr_q    <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_we_q   <= 1'b0;
            wb_rd_addr_q <= '0;
            wb_data_q    <= '0;
            misalign_q   <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            wb_rd_we_q <= 1'b0;
            misalign_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ex_fire) begin
                        if (!ex_is_mem) begin
                            wb_valid_q   <= 1'b1;
                            wb_rd_we_q   <= ex_rd_we && ex_rd_nz;
                            wb_rd_addr_q <= ex_rd_addr;
                            wb_data_q    <= ex_alu_result;
                        end else if (ex_misaligned) begin
                            wb_valid_q   <= 1'b1;
                            wb_rd_addr_q <= ex_rd_addr;
                            misalign_q   <= 1'b1;
                        end else begin
                            addr_q    <= ex_alu_result;
                            wdata_q   <= ex_mem_we ? ex_store_data : '0;
                            store_q   <= ex_mem_we;
                            rd_we_q   <= ex_rd_we && ex_rd_nz && !ex_mem_we;
                            rd_addr_q <= ex_rd_addr;
                            state_q   <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (dmem_req_ready) begin
                        if (store_q) begin
                            wb_valid_q   <= 1'b1;
                            wb_rd_addr_q <= rd_addr_q;
                            state_q      <= IDLE;
                        end else begin
                            state_q <= WAIT_RSP;
                        end
                    end
                end
                WAIT_RSP: begin
                    if (dmem_rsp_valid) begin
                        wb_valid_q   <= 1'b1;
                        wb_rd_we_q   <= rd_we_q;
                        wb_rd_addr_q <= rd_addr_q;
                        wb_data_q    <= dmem_rsp_rdata;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ex_ready       = (state_q == IDLE);
    assign dmem_req_valid = (state_q == REQ);
    assign dmem_req_we    = store_q;
    assign dmem_req_addr  = addr_q;
    assign dmem_req_wdata = wdata_q;

    assign wb_valid     = wb_valid_q;
    assign wb_rd_we     = wb_rd_we_q;
    assign wb_rd_addr   = wb_rd_addr_q;
    assign wb_data      = wb_data_q;
    assign misalign_err = misalign_q;
    assign dbg_state    = state_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage.
- Registers the execute-stage results (ALU result, store data, memory/writeback controls), performs 64-bit doubleword LD/SD accesses on the data-memory port with a valid/ready request and a response channel, and emits one writeback record per accepted instruction.
- Stalls upstream through ex_ready while a memory access is outstanding.

Parameters:
- XLEN, 64, data and address width.
- REG_ADDR_W, 5, register-index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- ex_valid  in  1  execute outputs valid this cycle.
- ex_ready  out  1  stage can accept; transfer when ex_valid && ex_ready.
- ex_alu_result  in  XLEN  ALU result, or effective address for LD/SD.
- ex_store_data  in  XLEN  SD data (rs2).
- ex_mem_we  in  1  instruction is a store.
- ex_mem_to_reg  in  1  instruction is a load.
- ex_rd_we  in  1  destination write enable.
- ex_rd_addr  in  REG_ADDR_W  destination register.
- dmem_req_valid  out  1  memory request valid.
- dmem_req_ready  in  1  memory accepts request.
- dmem_req_we  out  1  1 = write, 0 = read.
- dmem_req_addr  out  XLEN  byte address, doubleword aligned.
- dmem_req_wdata  out  XLEN  write data.
- dmem_rsp_valid  in  1  read data valid.
- dmem_rsp_rdata  in  XLEN  read data.
- wb_valid  out  1  writeback record valid (one-cycle pulse per instruction).
- wb_rd_we  out  1  register-file write enable.
- wb_rd_addr  out  REG_ADDR_W  destination register.
- wb_data  out  XLEN  writeback value.
- misalign_err  out  1  one-cycle pulse: LD/SD address[2:0] != 0.

Behaviour:
- Reset (rst_n low at a clock edge): state = IDLE. All outputs 0 except ex_ready = 1. Captured registers cleared. Applies mid-transaction: a pending request is dropped, and a response arriving after reset is ignored.
- FSM states: IDLE, REQ, WAIT_RSP. ex_ready = 1 only in IDLE (combinational from state).
- IDLE, on transfer, capture all ex_* fields:
  - Non-memory op (neither mem_we nor mem_to_reg): next cycle wb_valid = 1, wb_data = alu_result, wb_rd_we = rd_we && rd_addr != 0. Stay in IDLE. Back-to-back ALU ops run at one per cycle, latency 1.
  - Memory op with alu_result[2:0] != 0: no memory request. Next cycle wb_valid = 1, wb_rd_we = 0, misalign_err = 1. Stay in IDLE.
  - Aligned memory op: go to REQ.
  - mem_we and mem_to_reg both set: treated as a store; the rd write is suppressed.
- REQ:
  - dmem_req_valid = 1, with we/addr/wdata driven from the captured registers and held stable until the handshake.
  - dmem_req_wdata = store_data for a store, 0 for a load.
  - On dmem_req_ready: a store gives wb_valid = 1, wb_rd_we = 0 next cycle, then IDLE. A load goes to WAIT_RSP.
  - dmem_req_ready is ignored outside REQ.
- WAIT_RSP:
  - dmem_req_valid = 0.
  - On dmem_rsp_valid: next cycle wb_valid = 1, wb_data = rsp_rdata, wb_rd_we = captured rd_we && rd_addr != 0. Then IDLE.
  - dmem_rsp_valid in any other state is ignored.
- wb_* and misalign_err are registered outputs and are 0 (wb_data holds its last value) on cycles without a record.
- Minimum load latency: accept at cycle t, request at t+1 (ready same cycle), response at t+2, wb_valid at t+3. Minimum store latency: wb_valid at t+2.
- No wait limit: the FSM stays in REQ or WAIT_RSP indefinitely until the handshake.
- Re-acceptance: in the cycle wb_valid pulses for a memory op, state is already IDLE, so ex_ready = 1 and a new instruction may transfer that cycle.

Test Plan:
- ALU stream: three back-to-back transfers, alu_result 0x11, 0x22, 0x33 to rd 1, 2, 3 -> wb_valid on three consecutive cycles, wb_data 0x11/0x22/0x33, wb_rd_we = 1, ex_ready constantly 1.
- Store: SD addr 0x100, data 0xDEADBEEFCAFEF00D, req_ready held low 3 cycles -> dmem_req_valid high 4 cycles with stable addr/wdata, we = 1; ex_ready low throughout; wb_valid with wb_rd_we = 0 one cycle after ready.
- Load: LD addr 0x108 to rd 5, ready immediate, rsp 2 cycles later with 0x0123456789ABCDEF -> wb_data = 0x0123456789ABCDEF, wb_rd_addr = 5, wb_rd_we = 1. A spurious rsp_valid in IDLE produces no wb_valid.
- Misaligned: LD addr 0x10C -> no dmem_req_valid, misalign_err and wb_valid pulse together, wb_rd_we = 0.
- x0 target: ADD to rd 0 and LD to rd 0 -> wb_valid = 1, wb_rd_we = 0 for both.
- Reset mid-load: rst_n low in WAIT_RSP, then rsp_valid 1 cycle after release -> outputs 0, ex_ready = 1, no wb_valid.
